// File: rtl/seq_mag_comparator_pkg.sv
// Shared types and helpers for the slice-serial magnitude comparator.
package seq_mag_comparator_pkg;

  localparam int unsigned SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  // 74LS85-style cascade resolution used when every slice compared equal.
  function automatic cmp_res_t resolve_cascade(input logic gt_in, input logic lt_in,
                                               input logic eq_in);
    cmp_res_t r;
    if (eq_in) begin
      r = '{gt: 1'b0, lt: 1'b0, eq: 1'b1};
    end else begin
      r = '{gt: ~lt_in, lt: ~gt_in, eq: 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/slice_cmp4.sv
// Combinational 4-bit unsigned magnitude compare.
module slice_cmp4
  import seq_mag_comparator_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             gt_c,
  output logic             lt_c,
  output logic             eq_c
);

  always_comb begin
    gt_c = (a > b);
    lt_c = (a < b);
    eq_c = (a == b);
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: one 4-bit slice per cycle, MSB slice first,
// early exit on the first differing slice, cascade inputs resolve full equality.
module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  input  logic                             signed_mode,
  input  logic                             gt_in,
  input  logic                             lt_in,
  input  logic                             eq_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             a_gt_b,
  output logic                             a_lt_b,
  output logic                             a_eq_b,
  output logic [$clog2(WIDTH/4+1)-1:0]     slices_used
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned SU_W   = $clog2(NSLICE + 1);
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  cmp_res_t         casc_q;
  cmp_res_t         res_q, res_n;
  logic [SU_W-1:0]  su_n;
  logic             in_ready_n, out_valid_n;
  logic             load;

  logic [SLICE-1:0] slice_a, slice_b;
  logic             s_gt, s_lt, s_eq;

  // Slice mux; signed mode flips the sign bit of the MSB slice only.
  always_comb begin
    slice_a = SLICE'(a_q >> (SLICE * 32'(idx)));
    slice_b = SLICE'(b_q >> (SLICE * 32'(idx)));
    if (signed_q && (idx == IDX_TOP)) begin
      slice_a[SLICE-1] = ~slice_a[SLICE-1];
      slice_b[SLICE-1] = ~slice_b[SLICE-1];
    end
  end

  slice_cmp4 u_slice_cmp4 (
    .a    (slice_a),
    .b    (slice_b),
    .gt_c (s_gt),
    .lt_c (s_lt),
    .eq_c (s_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      casc_q      <= '0;
      res_q       <= '0;
      slices_used <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      res_q       <= res_n;
      slices_used <= su_n;
      in_ready    <= in_ready_n;
      out_valid   <= out_valid_n;
      if (load) begin
        a_q      <= a;
        b_q      <= b;
        signed_q <= signed_mode;
        casc_q   <= '{gt: gt_in, lt: lt_in, eq: eq_in};
      end
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    res_n       = res_q;
    su_n        = slices_used;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    load        = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          load       = 1'b1;
          idx_n      = IDX_TOP;
          in_ready_n = 1'b0;
          state_n    = CMP;
        end
      end

      CMP: begin
        if (!s_eq) begin
          res_n       = '{gt: s_gt, lt: s_lt, eq: 1'b0};
          su_n        = SU_W'(NSLICE - 32'(idx));
          out_valid_n = 1'b1;
          state_n     = DONE;
        end else if (idx != '0) begin
          idx_n = idx - 1'b1;
        end else begin
          res_n       = resolve_cascade(casc_q.gt, casc_q.lt, casc_q.eq);
          su_n        = SU_W'(NSLICE);
          out_valid_n = 1'b1;
          state_n     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          state_n     = IDLE;
        end
      end

      default: begin
        out_valid_n = 1'b0;
        in_ready_n  = 1'b1;
        state_n     = IDLE;
      end
    endcase
  end

  assign a_gt_b = res_q.gt;
  assign a_lt_b = res_q.lt;
  assign a_eq_b = res_q.eq;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator (WIDTH=16).
module tb_seq_mag_comparator;

  localparam int WIDTH = 16;
  localparam int NSL   = WIDTH / 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a, b;
  logic              signed_mode, gt_in, lt_in, eq_in;
  logic              out_valid, out_ready;
  logic              a_gt_b, a_lt_b, a_eq_b;
  logic [2:0]        slices_used;

  seq_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .gt_in       (gt_in),
    .lt_in       (lt_in),
    .eq_in       (eq_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a_gt_b      (a_gt_b),
    .a_lt_b      (a_lt_b),
    .a_eq_b      (a_eq_b),
    .slices_used (slices_used)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic gt;
    logic lt;
    logic eq;
    int   su;
    int   acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_cyc  = -10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic sm, input logic gi, input logic li, input logic ei);
    exp_t e;
    logic [3:0] na, nb;
    e.su  = 0;
    e.acc = 0;
    for (int i = NSL - 1; i >= 0; i--) begin
      na = av[4*i +: 4];
      nb = bv[4*i +: 4];
      if (e.su == 0 && na != nb) e.su = NSL - i;
    end
    if (e.su != 0) begin
      e.gt = sm ? ($signed(av) > $signed(bv)) : (av > bv);
      e.lt = !e.gt;
      e.eq = 1'b0;
    end else begin
      e.su = NSL;
      e.eq = 1'b0;
      if (ei)             begin e.gt = 1'b0; e.lt = 1'b0; e.eq = 1'b1; end
      else if (gi && !li) begin e.gt = 1'b1; e.lt = 1'b0; end
      else if (!gi && li) begin e.gt = 1'b0; e.lt = 1'b1; end
      else if (gi && li)  begin e.gt = 1'b0; e.lt = 1'b0; end
      else                begin e.gt = 1'b1; e.lt = 1'b1; end
    end
    return e;
  endfunction

  // Drive one operation, push its expectation at the accept edge.
  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sm,
                      input logic gi, input logic li, input logic ei,
                      input bit keep, input bit b2b_chk);
    exp_t e;
    int waited;
    @(negedge clk);
    a = av; b = bv; signed_mode = sm; gt_in = gi; lt_in = li; eq_in = ei;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(0), 32'(1));
      in_valid = 1'b0;
      return;
    end
    e = model(av, bv, sm, gi, li, ei);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    if (b2b_chk) check("b2b_gap", 32'(e.acc - hs_cyc), 32'(1));
    @(posedge clk);
    #1;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    signed_mode = 1'($urandom);
    {gt_in, lt_in, eq_in} = 3'($urandom);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
  endtask

  // Output monitor: compares every DONE cycle against the queue head.
  exp_t  head;
  logic  ov_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        check("no_spurious_valid", 32'(out_valid), 32'(0));
      end else if (out_valid) begin
        head = exp_q[0];
        check("a_gt_b", 32'(a_gt_b), 32'(head.gt));
        check("a_lt_b", 32'(a_lt_b), 32'(head.lt));
        check("a_eq_b", 32'(a_eq_b), 32'(head.eq));
        check("slices_used", 32'(slices_used), 32'(head.su));
        check("in_ready_busy", 32'(in_ready), 32'(0));
        if (!ov_prev) check("latency", 32'(cyc - head.acc), 32'(head.su));
        if (out_ready) begin
          hs_cyc = cyc + 1;
          void'(exp_q.pop_front());
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    int w;
    logic [WIDTH-1:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0; b = '0;
    signed_mode = 1'b0; gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(0));
    check("rst_slices_used", 32'(slices_used), 32'(0));
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));

    // Unsigned/signed MSB-slice decisions.
    send(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); drain();
    send(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); drain();

    // Full-equality cascade table.
    send(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); drain();
    send(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); drain();
    send(16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); drain();
    send(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); drain();
    send(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); drain();

    // Stalled consumer: result must hold, in_ready stays low until after handshake.
    @(posedge clk); #1 out_ready = 1'b0;
    send(16'h12A4, 16'h12A3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    w = 0;
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    check("stall_out_valid", 32'(out_valid), 32'(1));
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'(0));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    check("in_ready_before_hs", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    check("in_ready_after_hs", 32'(in_ready), 32'(1));
    drain();

    // Back-to-back with in_valid held high.
    send(16'h00F0, 16'h00E0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(16'h5555, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset in the middle of CMP (idx=2).
    send(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(0));
    check("midrst_slices_used", 32'(slices_used), 32'(0));
    @(negedge clk); #1 rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    repeat (6) @(negedge clk);
    send(16'hA5A5, 16'hA5A6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); drain();

    // Random operands differing in one random nibble (or equal).
    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = ra;
      if ($urandom_range(0, 4) != 0) rb = ra ^ (WIDTH'($urandom_range(1, 15)) << (4 * $urandom_range(0, NSL - 1)));
      send(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mag_comparator.md
SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter SLICE, default 4, bits compared per cycle; fixed at 4, not overridable.
REQ-003 Parameter NSLICE, default WIDTH/4, slice count, derived, not overridable.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  operands and mode are valid this cycle.
REQ-007 in_ready  output  1  block can accept operands this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-011 gt_in, lt_in, eq_in  input  1 each  cascade inputs, 74LS85 semantics.
REQ-012 out_valid  output  1  result is valid.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 a_gt_b, a_lt_b, a_eq_b  output  1 each  comparison result.
REQ-015 slices_used  output  clog2(NSLICE+1)  number of slices examined for the current result.

Function
REQ-016 The FSM SHALL have three states: IDLE, CMP and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 Accept occurs when in_valid and in_ready are both 1.
- On accept: latch a, b, signed_mode and the cascade inputs; set idx=NSLICE-1; go to CMP.
REQ-019 Each CMP cycle SHALL compare exactly one 4-bit slice [4*idx+3:4*idx], MSB slice first.
REQ-020 When signed_mode=1, the top bit of the MSB slice of both operands SHALL be inverted before that slice is compared; all other slices are unaffected.
REQ-021 Early exit: if the current slice differs, register gt/lt from that slice, set eq=0, set slices_used=NSLICE-idx, and go to DONE.
REQ-022 If the slice is equal and idx>0, decrement idx and stay in CMP.
REQ-023 If the slice is equal and idx==0, resolve the result from the latched cascade inputs:
- eq_in=1: gt=0, lt=0, eq=1.
- gt_in=1, lt_in=0: gt=1.
- gt_in=0, lt_in=1: lt=1.
- gt_in=1, lt_in=1: gt=0, lt=0.
- gt_in=0, lt_in=0: gt=1, lt=1.
- eq=0 in every case except eq_in=1.
- Then go to DONE with slices_used=NSLICE.
REQ-024 Latency SHALL be k cycles from the accept edge to out_valid=1, where k = slices examined (1..NSLICE).
REQ-025 In DONE, out_valid=1 and the result plus slices_used SHALL be held stable until out_ready=1.
REQ-026 When out_valid and out_ready are both 1: go to IDLE; in_ready rises the next cycle; no accept occurs in the same cycle.
REQ-027 Input changes outside the accept cycle SHALL NOT affect an in-flight compare.
REQ-028 Exactly one of a_gt_b, a_lt_b, a_eq_b SHALL be 1 in DONE, except for the cascade cases gt_in=lt_in=1 and gt_in=lt_in=0 with eq_in=0.
REQ-029 When WIDTH=4, the block SHALL always take one CMP cycle.

Reset
REQ-030 rst=1 SHALL force IDLE immediately, regardless of clk.
REQ-031 On reset, in_ready=1 once rst deasserts; out_valid=0; a_gt_b=a_lt_b=a_eq_b=0; slices_used=0; idx=0.
REQ-032 Reset in CMP or DONE SHALL discard the operation; no out_valid pulse follows it.

Structure
REQ-033 A shared package SHALL hold:
- the state enum (IDLE, CMP, DONE);
- the SLICE=4 constant;
- the cascade-resolution function.
REQ-034 One combinational sub-module, slice_cmp4, SHALL compare two 4-bit values and produce gt/lt/eq; it is instantiated once and fed by a slice mux.

Verification
REQ-035 WIDTH=16, unsigned, a=0x8000, b=0x7FFF -> gt=1, slices_used=1, out_valid 1 cycle after accept.
REQ-036 WIDTH=16, signed, a=0x8000, b=0x7FFF -> lt=1, slices_used=1.
REQ-037 WIDTH=16, a=b=0x1234, eq_in=1 -> eq=1, slices_used=4, latency 4; repeat with gt_in=lt_in=0, eq_in=0 -> gt=1, lt=1, eq=0.
REQ-038 WIDTH=16, a=0x12A4, b=0x12A3; out_ready held 0 for 5 cycles -> lt=0, gt=1, slices_used=4, result stable throughout, in_ready=0 until the cycle after the handshake.
REQ-039 Back-to-back stimulus with in_valid held 1 -> second accept occurs exactly 1 cycle after out_valid&out_ready.
REQ-040 Assert rst mid-CMP, at idx=2 -> outputs go to reset values asynchronously; no out_valid; the next operation completes correctly.
